// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one uart_tx byte channel
// between NUM_REQ requesters through a one-entry registered output stage.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 64,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [ID_W-1:0]         last;
  logic [CNT_W-1:0]        burst_cnt;

  logic [ID_W-1:0]         pick;
  logic [ID_W-1:0]         cand;
  logic                    any_req;
  logic                    req_xfer;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;

  // Round-robin scan starting one past the most recent grantee.
  always_comb begin
    pick    = last;
    cand    = last;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last) + k) % NUM_REQ);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  // Only the grantee sees ready, and only when the output register can take a byte.
  always_comb begin
    req_ready = '0;
    if (state == SEND) begin
      req_ready[grant_id] = !tx_valid || tx_ready;
    end
  end

  assign g_data   = req_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
  assign g_last   = req_last[grant_id];
  assign req_xfer = req_valid[grant_id] && req_ready[grant_id];
  assign busy     = (state == SEND) || tx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      burst_cnt <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      // A load in SEND below overrides this drain when both happen together.
      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= pick;
            last      <= pick;
            burst_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (req_xfer) begin
            tx_data   <= g_data;
            tx_valid  <= 1'b1;
            burst_cnt <= burst_cnt + CNT_W'(1);
            if (g_last || (burst_cnt == CNT_W'(MAX_BURST - 1))) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT,
// accepted tx bytes are logged and compared against hand-computed sequences.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [1:0]    grant_id;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  logic [8:0]    rq_mem [NR][16];
  int            rq_head [NR];
  int            rq_tail [NR];
  logic [NR-1:0] en;
  logic [7:0]    out_log [64];
  int            out_n;
  logic [NR-1:0] rr_seen;
  int            cyc;
  int            vectors;
  int            miscompares;

  task automatic push(input int r, input logic [7:0] b, input logic l);
    rq_mem[r][rq_tail[r]] = {l, b};
    rq_tail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && rq_head[i] < rq_tail[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = rq_mem[i][rq_head[i]][7:0];
        req_last[i]           = rq_mem[i][rq_head[i]][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  // Handshakes are sampled mid-cycle; queues and log advance just after the edge.
  task automatic cycle();
    logic [NR-1:0] rx;
    logic          txx;
    logic [7:0]    d;
    @(negedge clk);
    rx      = req_valid & req_ready;
    txx     = tx_valid & tx_ready;
    d       = tx_data;
    rr_seen = rr_seen | req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (rx[i]) rq_head[i]++;
    if (txx && out_n < 64) begin
      out_log[out_n] = d;
      out_n++;
    end
    drive();
    cyc++;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    out_n   = 0;
    en      = '1;
    rr_seen = '0;
    cyc     = 0;
    drive();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    clear_bench();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_ready = 1'b1;
    clear_bench();
    cycle();
    cycle();
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst = 1'b0;
    cycle();
    vectors++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL idle_quiet got busy=%0b ready=%b want 0/0000", busy, req_ready); end
  endtask

  task automatic test_single();
    logic [7:0] exp [3];
    exp = '{8'h41, 8'h42, 8'h43};
    apply_reset();
    tx_ready = 1'b1;
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b0);
    push(1, 8'h43, 1'b1);
    drive();
    cyc = 0;
    for (int n = 0; n < 50 && out_n < 3; n++) cycle();
    vectors++; if (out_n !== 3) begin miscompares++; $display("FAIL single_count got %0d want 3", out_n); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (out_log[i] !== exp[i]) begin miscompares++; $display("FAIL single_byte%0d got %h want %h", i, out_log[i], exp[i]); end
    end
    vectors++; if (cyc !== 5) begin miscompares++; $display("FAIL single_latency got %0d cycles want 5", cyc); end
    vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL single_grant got %0d want 1", grant_id); end
    vectors++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin miscompares++; $display("FAIL single_done got busy=%0b tx_valid=%0b want 0/0", busy, tx_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [8];
    exp = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
    apply_reset();
    tx_ready = 1'b1;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    drive();
    for (int n = 0; n < 100 && out_n < 8; n++) cycle();
    vectors++; if (out_n !== 8) begin miscompares++; $display("FAIL rr_count got %0d want 8", out_n); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (out_log[i] !== exp[i]) begin miscompares++; $display("FAIL rr_byte%0d got %h want %h", i, out_log[i], exp[i]); end
    end
    vectors++; if (grant_id !== 2'd2) begin miscompares++; $display("FAIL rr_grant got %0d want 2", grant_id); end
  endtask

  task automatic test_lock();
    logic [7:0] exp [3];
    exp = '{8'hA0, 8'hA1, 8'hB0};
    apply_reset();
    tx_ready = 1'b1;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1);
    drive();
    for (int n = 0; n < 20 && rq_head[0] < 1; n++) cycle();
    vectors++; if (rq_head[0] !== 1) begin miscompares++; $display("FAIL lock_first got %0d accepted want 1", rq_head[0]); end
    en[0] = 1'b0;
    drive();
    for (int n = 0; n < 5; n++) cycle();
    vectors++; if (grant_id !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL lock_hold got grant=%0d busy=%0b want 0/1", grant_id, busy); end
    en[0] = 1'b1;
    drive();
    for (int n = 0; n < 20 && rq_head[0] < 2; n++) cycle();
    vectors++; if (rr_seen[1] !== 1'b0) begin miscompares++; $display("FAIL lock_ready1 got %0b want 0", rr_seen[1]); end
    for (int n = 0; n < 40 && out_n < 3; n++) cycle();
    vectors++; if (out_n !== 3) begin miscompares++; $display("FAIL lock_count got %0d want 3", out_n); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (out_log[i] !== exp[i]) begin miscompares++; $display("FAIL lock_byte%0d got %h want %h", i, out_log[i], exp[i]); end
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp [11];
    exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    apply_reset();
    tx_ready = 1'b1;
    for (int b = 0; b < 10; b++) push(0, 8'(b), 1'b0);
    push(3, 8'hFF, 1'b1);
    drive();
    for (int n = 0; n < 150 && out_n < 11; n++) cycle();
    vectors++; if (out_n !== 11) begin miscompares++; $display("FAIL burst_count got %0d want 11", out_n); end
    for (int i = 0; i < 11; i++) begin
      vectors++; if (out_log[i] !== exp[i]) begin miscompares++; $display("FAIL burst_byte%0d got %h want %h", i, out_log[i], exp[i]); end
    end
    vectors++; if (grant_id !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL burst_locked got grant=%0d busy=%0b want 0/1", grant_id, busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3];
    exp = '{8'h55, 8'h56, 8'h57};
    apply_reset();
    tx_ready = 1'b0;
    push(2, 8'h55, 1'b0); push(2, 8'h56, 1'b0); push(2, 8'h57, 1'b1);
    drive();
    for (int n = 0; n < 20 && tx_valid !== 1'b1; n++) cycle();
    vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %0b want 1", tx_valid); end
    for (int n = 0; n < 20; n++) begin
      cycle();
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h55 || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_stall%0d got valid=%0b data=%h ready=%b want 1/55/0000", n, tx_valid, tx_data, req_ready);
      end
    end
    vectors++; if (rq_head[2] !== 1 || out_n !== 0) begin miscompares++; $display("FAIL bp_nolose got accepted=%0d sent=%0d want 1/0", rq_head[2], out_n); end
    tx_ready = 1'b1;
    for (int n = 0; n < 40 && out_n < 3; n++) cycle();
    vectors++; if (out_n !== 3) begin miscompares++; $display("FAIL bp_count got %0d want 3", out_n); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (out_log[i] !== exp[i]) begin miscompares++; $display("FAIL bp_byte%0d got %h want %h", i, out_log[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tx_ready = 1'b0;
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b1);
    drive();
    for (int n = 0; n < 20 && tx_valid !== 1'b1; n++) cycle();
    vectors++; if (tx_valid !== 1'b1 || grant_id !== 2'd1) begin miscompares++; $display("FAIL rm_setup got valid=%0b grant=%0d want 1/1", tx_valid, grant_id); end
    rst = 1'b1;
    cycle();
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rm_tx_valid got %0b want 0", tx_valid); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rm_req_ready got %b want 0000", req_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %0b want 0", busy); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rm_grant got %0d want 0", grant_id); end
    rst = 1'b0;
    clear_bench();
    tx_ready = 1'b1;
    push(0, 8'h70, 1'b1);
    push(3, 8'h73, 1'b1);
    drive();
    for (int n = 0; n < 40 && out_n < 2; n++) cycle();
    vectors++; if (out_n !== 2) begin miscompares++; $display("FAIL rm_count got %0d want 2", out_n); end
    vectors++; if (out_log[0] !== 8'h70) begin miscompares++; $display("FAIL rm_first got %h want 70", out_log[0]); end
    vectors++; if (out_log[1] !== 8'h73) begin miscompares++; $display("FAIL rm_second got %h want 73", out_log[1]); end
  endtask

  initial begin
    rst         = 1'b1;
    tx_ready    = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_burst();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
